// File: rtl/sram_pkg.sv
// Shared SRAM definitions: state encoding, default geometry, saturating counter helper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package sram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Event counters stop at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == {CNT_W{1'b1}}) ? v : cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Asynchronous SRAM control and address pins, as seen from the memory side.
// Latency: wires only.
// Backpressure: none; the driver owns every strobe.
interface sram_responder_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              CSX;
    logic              OEX;
    logic              WEX;
    logic [ADDR_W-1:0] ADDR;

    // The SRAM driver side.
    modport master (output CSX, OEX, WEX, ADDR);
    // The responder (memory model) side.
    modport slave  (input  CSX, OEX, WEX, ADDR);

endinterface

// File: rtl/sram_mem.sv
// Single-port synchronous RAM with a write enable and a registered read port.
// Latency: read data appears 1 clk after the address; a write lands on the same edge.
// Backpressure: none; the memory accepts one access every cycle. There is no reset.
module sram_mem
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write when enabled. The read is registered so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_responder.sv
// Responds to an asynchronous-SRAM driver: captures writes, serves reads, and counts both.
// Latency: a write commits when WEX rises. Read data follows the address by 1 clk.
// Backpressure: none. DATA goes to Z combinationally as soon as the read conditions drop.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] DATA,
    output cnt_t              wr_count,
    output cnt_t              rd_count,
    output logic              err
);

    logic [1:0]        rst_sync;
    logic              rst_core_n;
    state_t            state;
    state_t            state_nxt;
    logic              cs;
    logic              we;
    logic              oe;
    logic              data_oe;
    logic              latch;
    logic              commit;
    logic              conflict;
    logic              rd_drove;
    logic              rd_drove_nxt;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_rdata;
    cnt_t              wr_count_nxt;
    cnt_t              rd_count_nxt;

    // Convert the active-low strobes to active-high once.
    assign cs = ~bus.CSX;
    assign we = ~bus.WEX;
    assign oe = ~bus.OEX;

    // Reset asserts immediately. Release is retimed through two flops, so nothing moves before the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];

    // State register.
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: deselect always returns to IDLE, and a write strobe wins over a read.
    always_comb begin
        state_nxt = state;
        if (!cs) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        state_nxt = WRITE;
                    end else if (oe) begin
                        state_nxt = READ;
                    end
                end
                WRITE: begin
                    if (!we) begin
                        state_nxt = IDLE;
                    end
                end
                READ: begin
                    if (we) begin
                        state_nxt = WRITE;
                    end else if (!oe) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decode bus enable, write capture and commit, memory address, and the next counter values.
    always_comb begin
        data_oe      = (state == READ) && cs && oe && !we;
        latch        = cs && we;
        conflict     = cs && we && oe;
        commit       = (state == WRITE) && (!cs || !we);
        // The commit edge owns the single RAM port. A read can never need that edge, because WRITE always exits through IDLE.
        mem_addr     = commit ? waddr : bus.ADDR;
        rd_drove_nxt = (state_nxt == READ) && (rd_drove || data_oe);
        wr_count_nxt = commit ? sat_inc(wr_count) : wr_count;
        rd_count_nxt = ((state == READ) && (state_nxt != READ) && rd_drove)
                       ? sat_inc(rd_count) : rd_count;
    end

    // Write capture (the last sample while WEX is low wins), counters, and the sticky conflict flag.
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            waddr    <= '0;
            wdata    <= '0;
            wr_count <= '0;
            rd_count <= '0;
            rd_drove <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (latch) begin
                waddr <= bus.ADDR;
                wdata <= DATA;
            end
            wr_count <= wr_count_nxt;
            rd_count <= rd_count_nxt;
            rd_drove <= rd_drove_nxt;
            if (conflict) begin
                err <= 1'b1;
            end
        end
    end

    sram_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (commit),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    // The shared bus is driven only during an active read.
    assign DATA = data_oe ? mem_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed and random SRAM bus transactions, checked against a transaction-level reference.
// Latency: drives at negedge, samples 1 time unit later, and reads registered results after the edge.
// Backpressure: not applicable.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(AW)) bus ();

    wire  [DW-1:0] data_bus;
    logic          tb_drv;
    logic [DW-1:0] tb_dat;
    assign data_bus = tb_drv ? tb_dat : {DW{1'bz}};

    logic [15:0] wr_count_o;
    logic [15:0] rd_count_o;
    logic        err_o;

    sram_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .DATA     (data_bus),
        .wr_count (wr_count_o),
        .rd_count (rd_count_o),
        .err      (err_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference: memory contents, the addresses known to be written, and the expected status outputs.
    logic [15:0] mem_m [logic [7:0]];
    logic [7:0]  addr_q [$];
    logic [15:0] wr_m;
    logic [15:0] rd_m;
    logic        err_m;

    function automatic logic [15:0] sat(input logic [15:0] v);
        int s;
        s = int'(v) + 1;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic logic [7:0] pick();
        return addr_q[$urandom_range(0, addr_q.size() - 1)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic csx, input logic oex, input logic wex,
                           input logic [7:0] a, input logic drv, input logic [15:0] d);
        bus.CSX  = csx;
        bus.OEX  = oex;
        bus.WEX  = wex;
        bus.ADDR = a;
        tb_drv   = drv;
        tb_dat   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_bus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
        repeat (n) tick();
    endtask

    // Hold WEX low for n cycles (n <= 3) with data d0/d1/d2, then release WEX (or CSX when cs_exit is set).
    task automatic do_write(input logic [7:0] a, input int n,
                            input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                            input bit cs_exit);
        logic [15:0] d;
        d = d0;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            set_bus(1'b0, 1'b1, 1'b0, a, 1'b1, d);
            #1;
            chk("wr_no_drive", 32'(dut.data_oe), 32'd0);
            tick();
        end
        if (cs_exit) set_bus(1'b1, 1'b1, 1'b1, a, 1'b0, 16'h0000);
        else         set_bus(1'b0, 1'b1, 1'b1, a, 1'b0, 16'h0000);
        tick();
        if (!mem_m.exists(a)) addr_q.push_back(a);
        mem_m[a] = d;
        wr_m = sat(wr_m);
        chk("wr_count", 32'(wr_count_o), 32'(wr_m));
        chk("wr_err", 32'(err_o), 32'(err_m));
    endtask

    // Hold OEX low for n cycles, at address a0 or at random written addresses.
    // mode 0: end by raising OEX; mode 1: end by raising CSX; mode 2: end with a conflicting write of BEEF to 0x40.
    task automatic do_read(input logic [7:0] a0, input bit rnd, input int n, input int mode);
        logic [7:0] a;
        logic [7:0] prev;
        prev = a0;
        for (int i = 0; i < n; i++) begin
            a = rnd ? pick() : a0;
            set_bus(1'b0, 1'b0, 1'b1, a, 1'b0, 16'h0000);
            #1;
            if (i == 0) begin
                chk("rd_first_z", 32'(dut.data_oe), 32'd0);
            end else begin
                chk("rd_oe", 32'(dut.data_oe), 32'd1);
                chk("rd_data", 32'(data_bus), 32'(mem_m[prev]));
            end
            prev = a;
            tick();
        end
        if (n >= 2) rd_m = sat(rd_m);
        if (mode == 2) begin
            set_bus(1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 16'hBEEF);
            #1;
            chk("conflict_no_drive", 32'(dut.data_oe), 32'd0);
            tick();
            set_bus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
            tick();
            if (!mem_m.exists(8'h40)) addr_q.push_back(8'h40);
            mem_m[8'h40] = 16'hBEEF;
            wr_m  = sat(wr_m);
            err_m = 1'b1;
            chk("conflict_wr_count", 32'(wr_count_o), 32'(wr_m));
        end else begin
            if (mode == 1) set_bus(1'b1, 1'b0, 1'b1, prev, 1'b0, 16'h0000);
            else           set_bus(1'b0, 1'b1, 1'b1, prev, 1'b0, 16'h0000);
            #1;
            chk("rd_exit_z", 32'(dut.data_oe), 32'd0);
            tick();
        end
        chk("rd_count", 32'(rd_count_o), 32'(rd_m));
        chk("rd_err", 32'(err_o), 32'(err_m));
    endtask

    initial begin
        wr_m  = 16'h0000;
        rd_m  = 16'h0000;
        err_m = 1'b0;
        set_bus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        idle(10);

        // Reset state after a deselected idle period.
        chk("rst_data_z", 32'(dut.data_oe), 32'd0);
        chk("rst_wr_count", 32'(wr_count_o), 32'd0);
        chk("rst_rd_count", 32'(rd_count_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // Single-cycle write, then an immediate three-cycle read of the same word.
        do_write(8'h12, 1, 16'hA5C3, 16'h0000, 16'h0000, 1'b0);
        do_read(8'h12, 1'b0, 3, 0);

        // Three-cycle write: the trailing sample is committed, once.
        do_write(8'h05, 3, 16'h0001, 16'h0002, 16'h0003, 1'b1);
        do_read(8'h05, 1'b0, 2, 1);

        // Read interrupted by a write with OEX still low: no drive, the write commits, err sticks.
        do_read(8'h12, 1'b0, 2, 2);
        idle(3);
        chk("err_sticky", 32'(err_o), 32'd1);
        do_read(8'h40, 1'b0, 2, 0);

        // Random transactions; the read address changes every cycle.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(8'($urandom), int'($urandom_range(1, 3)), 16'($urandom),
                         16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                do_read(8'h00, 1'b1, int'($urandom_range(1, 4)), int'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // Reset in the middle of a write discards the pending commit.
        do_write(8'h20, 1, 16'h7777, 16'h0000, 16'h0000, 1'b1);
        set_bus(1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 16'h1234);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_count", 32'(wr_count_o), 32'd0);
        chk("midrst_rd_count", 32'(rd_count_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        tick();
        set_bus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
        tick();
        rst_n = 1'b1;
        wr_m  = 16'h0000;
        rd_m  = 16'h0000;
        err_m = 1'b0;
        idle(4);
        chk("postrst_wr_count", 32'(wr_count_o), 32'd0);
        do_read(8'h20, 1'b0, 2, 0);

        // Saturation: preload the write counter near the top so the limit is reached in a few writes.
        idle(1);
        force dut.wr_count = 16'hFFFD;
        tick();
        release dut.wr_count;
        wr_m = 16'hFFFD;
        chk("sat_preload", 32'(wr_count_o), 32'(wr_m));
        for (int k = 0; k < 3; k++) begin
            do_write(8'($urandom), 1, 16'($urandom), 16'h0000, 16'h0000, 1'b0);
        end
        chk("sat_hold", 32'(wr_count_o), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, word width on DATA.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 CSX  input  1  chip select, active-low.
REQ-006 OEX  input  1  output enable, active-low.
REQ-007 WEX  input  1  write enable, active-low.
REQ-008 ADDR  input  ADDR_W  word address from the SRAM driver.
REQ-009 DATA  inout  DATA_W  shared data bus; driven only during a read, else Z.
REQ-010 wr_count  output  16  committed-write counter.
REQ-011 rd_count  output  16  completed-read counter.
REQ-012 err  output  1  sticky bus-conflict flag.

Function
REQ-013 Three states: IDLE, WRITE, READ; state register updated on clk only.
REQ-014 IDLE->WRITE when CSX=0 and WEX=0; IDLE->READ when CSX=0, WEX=1, OEX=0; otherwise stay IDLE.
REQ-015 In WRITE, every cycle with CSX=0 and WEX=0 latches ADDR into waddr and DATA into wdata.
REQ-016 WRITE exits on first cycle with WEX=1 or CSX=1; on that edge mem[waddr]<=wdata is committed exactly once, wr_count increments, state -> IDLE.
REQ-017 Write data committed is the last value latched while WEX=0 (trailing-edge semantics); a write pulse of one cycle is valid.
REQ-018 In READ, memory is read at ADDR with one-cycle latency: DATA carries mem[ADDR sampled previous cycle] from the second cycle of OEX=0 onward.
REQ-019 DATA drive enable = (state==READ) AND CSX=0 AND OEX=0 AND WEX=1, combinational on the pins, so DATA goes Z in the same cycle OEX, CSX rises or WEX falls.
REQ-020 READ exits to IDLE on first cycle with CSX=1 or OEX=1; rd_count increments once per READ exit that drove DATA at least one cycle.
REQ-021 READ->WRITE directly if WEX=0 with CSX=0; no read-count increment unless DATA was driven.
REQ-022 CSX=0, WEX=0, OEX=0 simultaneously: write dominates, DATA not driven, err set and held until reset.
REQ-023 Changing ADDR during READ updates DATA one cycle later; no state change.
REQ-024 Write followed immediately by read of the same address returns the newly committed word (commit precedes read port access).
REQ-025 wr_count and rd_count saturate at 16'hFFFF, no wrap.
REQ-026 CSX=1 forces IDLE next cycle from any state and DATA=Z immediately.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, DATA=Z, wr_count=0, rd_count=0, err=0, waddr/wdata=0.
REQ-028 Reset during WRITE discards the pending commit; memory contents unchanged.
REQ-029 Memory array is not reset; contents after power-up are undefined.
REQ-030 Deassertion of rst_n is synchronized to clk; first state transition no earlier than the second rising edge after release.

Structure
REQ-031 Shared package sram_pkg holds the state encoding (IDLE/WRITE/READ) and default ADDR_W/DATA_W constants, shared with the SRAM driver bench.
REQ-032 One sub-module sram_mem: single-port synchronous RAM, write-enable port and registered read, no reset, inferable as block RAM.
REQ-033 Tristate buffer on DATA lives in sram_responder top level only.

Verification
REQ-034 Reset release, CSX=1 idle 10 cycles -> DATA=Z, counts 0, err=0, state IDLE.
REQ-035 Write 16'hA5C3 to ADDR 8'h12 with WEX low 1 cycle, then OEX low 3 cycles at ADDR 8'h12 -> DATA=16'hA5C3 from 2nd OEX cycle, wr_count=1, rd_count=1.
REQ-036 WEX low 3 cycles at ADDR 8'h05 with DATA 16'h0001, 16'h0002, 16'h0003 -> mem[8'h05]=16'h0003, wr_count=1.
REQ-037 CSX=0, OEX=0, WEX=0 with DATA 16'hBEEF -> responder never drives DATA, write commits 16'hBEEF, err=1 stays after bus idles.
REQ-038 Assert rst_n=0 mid-write (WEX low, ADDR 8'h20, DATA 16'h1234) -> mem[8'h20] keeps prior value, counts 0.
REQ-039 During READ raise OEX -> DATA=Z in the same cycle; 65536+ writes -> wr_count holds 16'hFFFF.
